// File: rtl/custom_result_writer_pkg.sv
// Shared definitions for the result writer: FSM encoding, lane count, memory address width.
package custom_result_writer_pkg;
  localparam int LANES  = 4;
  localparam int ADDR_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;
endpackage

// File: rtl/custom_sat_quant.sv
// Combinational quantizer: arithmetic right shift by SHIFT, then saturate to signed 8 bits.
// No state, no flow control; output follows input within the same cycle.
module custom_sat_quant #(
  parameter int ACC_W = 16,
  parameter int SHIFT = 4
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [7:0]       q
);
  localparam logic signed [ACC_W-1:0] Q_MAX = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] Q_MIN = ACC_W'(-128);

  logic signed [ACC_W-1:0] shifted;

  assign shifted = acc >>> SHIFT;

  always_comb begin
    if (shifted > Q_MAX)      q = 8'sh7f;
    else if (shifted < Q_MIN) q = 8'sh80;
    else                      q = shifted[7:0];
  end
endmodule

// File: rtl/custom_result_writer.sv
// Captures four accumulator lanes, clears them, writes quantized bytes to consecutive addresses.
// Fixed 7-cycle job (capture, 4 writes, done); start requests while busy are dropped, never queued.
module custom_result_writer
  import custom_result_writer_pkg::*;
#(
  parameter int                ACC_W     = 16,
  parameter int                SHIFT     = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 6'd32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   acc_valid_i,
  input  logic [LANES*ACC_W-1:0] acc_data_i,
  output logic [LANES-1:0]       acc_clr_o,
  output logic [ADDR_W-1:0]      addr_o,
  output logic                   we_o,
  output logic [7:0]             mem_data_o,
  output logic                   busy_o,
  output logic                   is_done_o
);
  state_t                   state_q, state_d;
  logic [1:0]               lane_q;
  logic [LANES*ACC_W-1:0]   cap_q;
  logic signed [ACC_W-1:0]  sel_acc;
  logic signed [7:0]        q_lane;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane_q <= 2'd0;
      cap_q  <= '0;
    end else begin
      if (state_q == ST_IDLE && en && acc_valid_i) cap_q <= acc_data_i;
      if (state_q == ST_CAPTURE)    lane_q <= 2'd0;
      else if (state_q == ST_WRITE) lane_q <= lane_q + 2'd1;
    end
  end

  // Single quantizer shared across lanes; the captured copy isolates it from live accumulators.
  assign sel_acc = cap_q[lane_q*ACC_W +: ACC_W];

  custom_sat_quant #(
    .ACC_W (ACC_W),
    .SHIFT (SHIFT)
  ) u_quant (
    .acc (sel_acc),
    .q   (q_lane)
  );

  always_comb begin
    state_d    = state_q;
    acc_clr_o  = '0;
    addr_o     = '0;
    we_o       = 1'b0;
    mem_data_o = '0;
    busy_o     = 1'b1;
    is_done_o  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy_o = 1'b0;
        if (en && acc_valid_i) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        acc_clr_o = '1;
        state_d   = ST_WRITE;
      end
      ST_WRITE: begin
        we_o       = 1'b1;
        addr_o     = BASE_ADDR + ADDR_W'(lane_q);
        mem_data_o = q_lane;
        if (lane_q == 2'd3) state_d = ST_DONE;
      end
      ST_DONE: begin
        is_done_o = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end
endmodule

// File: tb/tb_custom_result_writer.sv
// Randomized bench for custom_result_writer; two instances (base 32 and base 62) share stimulus.
module tb_custom_result_writer;
  localparam int ACC_W = 16;
  localparam int SHIFT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        acc_valid_i = 1'b0;
  logic [63:0] acc_data_i = '0;

  logic [3:0] clr_a, clr_b;
  logic [5:0] addr_a, addr_b;
  logic       we_a, we_b, busy_a, busy_b, done_a, done_b;
  logic [7:0] data_a, data_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  custom_result_writer #(.ACC_W(ACC_W), .SHIFT(SHIFT), .BASE_ADDR(6'd32)) dut_a (
    .clk(clk), .rst(rst), .en(en), .acc_valid_i(acc_valid_i), .acc_data_i(acc_data_i),
    .acc_clr_o(clr_a), .addr_o(addr_a), .we_o(we_a), .mem_data_o(data_a),
    .busy_o(busy_a), .is_done_o(done_a));

  custom_result_writer #(.ACC_W(ACC_W), .SHIFT(SHIFT), .BASE_ADDR(6'd62)) dut_b (
    .clk(clk), .rst(rst), .en(en), .acc_valid_i(acc_valid_i), .acc_data_i(acc_data_i),
    .acc_clr_o(clr_b), .addr_o(addr_b), .we_o(we_b), .mem_data_o(data_b),
    .busy_o(busy_b), .is_done_o(done_b));

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference quantizer: floor division by 2^SHIFT, then clamp to [-128,127].
  function automatic int qref(input int x);
    int p;
    int d;
    p = 1 << SHIFT;
    d = x / p;
    if (x < 0 && (x % p) != 0) d = d - 1;
    if (d > 127)  d = 127;
    if (d < -128) d = -128;
    return d;
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, int'(busy_a) + int'(busy_b), 0);
    chk({tag, "_we"},   int'(we_a) + int'(we_b), 0);
    chk({tag, "_clr"},  int'(clr_a) + int'(clr_b), 0);
    chk({tag, "_done"}, int'(done_a) + int'(done_b), 0);
  endtask

  // Called at a negedge; presents a start, then checks cycles 1..7 of the job.
  task automatic run_job(input logic [63:0] d, input bit hold, input bit scramble);
    int exp_q[4];
    int w;
    for (int k = 0; k < 4; k++) exp_q[k] = qref(int'($signed(d[k*16 +: 16])));
    acc_data_i  = d;
    en          = 1'b1;
    acc_valid_i = 1'b1;
    for (int cyc = 1; cyc <= 7; cyc++) begin
      @(negedge clk);
      w = cyc - 2;
      chk("busy",  int'(busy_a), (cyc <= 6) ? 1 : 0);
      chk("clr",   int'(clr_a), (cyc == 1) ? 15 : 0);
      chk("clr_b", int'(clr_b), (cyc == 1) ? 15 : 0);
      chk("we",    int'(we_a), (cyc >= 2 && cyc <= 5) ? 1 : 0);
      chk("addr",  int'(addr_a), (cyc >= 2 && cyc <= 5) ? (32 + w) % 64 : 0);
      chk("addr_b", int'(addr_b), (cyc >= 2 && cyc <= 5) ? (62 + w) % 64 : 0);
      chk("data",  int'($signed(data_a)), (cyc >= 2 && cyc <= 5) ? exp_q[w] : 0);
      chk("data_b", int'($signed(data_b)), (cyc >= 2 && cyc <= 5) ? exp_q[w] : 0);
      chk("done",  int'(done_a), (cyc == 6) ? 1 : 0);
      if (cyc < 7) begin
        en          = hold ? 1'b1 : 1'($urandom);
        acc_valid_i = hold ? 1'b1 : 1'($urandom);
        if (scramble) acc_data_i = {$urandom, $urandom};
      end else begin
        en          = hold;
        acc_valid_i = hold;
      end
    end
  endtask

  initial begin
    logic [63:0] d;
    bit hold;
    int gap;

    #2;
    chk_quiet("reset");
    chk("reset_addr", int'(addr_a) + int'(addr_b), 0);
    chk("reset_data", int'(data_a) + int'(data_b), 0);
    en = 1'b1;
    acc_valid_i = 1'b1;
    repeat (2) @(negedge clk);
    chk_quiet("in_reset_start");
    rst = 1'b1;

    // Directed: rounding and saturation vectors; start sampled at first edge after release.
    run_job({16'(-3000), 16'(2000), 16'(-50), 16'(100)}, 1'b0, 1'b1);
    run_job({16'(-17), 16'(16), 16'(-4096), 16'(4095)}, 1'b0, 1'b0);

    // en without valid must do nothing.
    en = 1'b1;
    acc_valid_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk_quiet("en_no_valid");
    end

    // en held high: back-to-back jobs restart at cycle 7.
    run_job({16'(7), 16'(-7), 16'(32767), 16'(-32768)}, 1'b1, 1'b1);
    run_job({$urandom, $urandom}, 1'b0, 1'b0);

    // Reset during the second write cycle.
    acc_data_i = {16'(500), 16'(-500), 16'(1000), 16'(-1000)};
    en = 1'b1;
    acc_valid_i = 1'b1;
    for (int cyc = 1; cyc <= 3; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        en = 1'b0;
        acc_valid_i = 1'b0;
        acc_data_i = '0;
      end
    end
    chk("pre_rst_we", int'(we_a), 1);
    chk("pre_rst_addr", int'(addr_a), 33);
    #2 rst = 1'b0;
    #1;
    chk("async_we", int'(we_a) + int'(we_b), 0);
    chk("async_addr", int'(addr_a) + int'(addr_b), 0);
    chk("async_data", int'(data_a) + int'(data_b), 0);
    chk("async_busy", int'(busy_a) + int'(busy_b), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_quiet("held_rst");
    end
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_quiet("after_rst");
    end
    run_job({16'(-1), 16'(1600), 16'(-2048), 16'(2047)}, 1'b0, 1'b1);

    // Randomized jobs with random idle gaps and random ignored traffic while busy.
    hold = 1'b0;
    for (int j = 0; j < 40; j++) begin
      if (!hold) begin
        gap = int'($urandom_range(0, 3));
        for (int g = 0; g < gap; g++) begin
          en = 1'($urandom);
          acc_valid_i = 1'b0;
          acc_data_i = {$urandom, $urandom};
          @(negedge clk);
          chk_quiet("gap");
        end
      end
      d = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) d[15:0] = 16'($signed(int'($urandom_range(0, 4000))) - 2000);
      hold = ($urandom_range(0, 4) == 0);
      run_job(d, hold, 1'($urandom));
    end
    en = 1'b0;
    acc_valid_i = 1'b0;
    @(negedge clk);
    chk_quiet("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/custom_result_writer.md
CUSTOM_RESULT_WRITER -- requirements
Module: custom_result_writer

Interface
REQ-001 SHALL have parameter ACC_W, default 16, signed accumulator width per lane.
REQ-002 SHALL have parameter SHIFT, default 4, arithmetic right-shift applied before saturation (0 to ACC_W-8).
REQ-003 SHALL have parameter BASE_ADDR, default 6'd32, first memory address written.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port en  input  1  start request, level-sampled in IDLE only.
REQ-007 SHALL have port acc_valid_i  input  1  all four accumulator lanes hold final results.
REQ-008 SHALL have port acc_data_i  input  4*ACC_W  lane k at bits [k*ACC_W +: ACC_W], signed.
REQ-009 SHALL have port acc_clr_o  output  4  one-hot-per-lane clear to accumulators, all bits equal.
REQ-010 SHALL have port addr_o  output  6  memory write address.
REQ-011 SHALL have port we_o  output  1  memory write enable.
REQ-012 SHALL have port mem_data_o  output  8  signed quantized write data.
REQ-013 SHALL have port busy_o  output  1  high in every state except IDLE.
REQ-014 SHALL have port is_done_o  output  1  single-cycle completion pulse.

Function
REQ-015 SHALL implement FSM states IDLE, CAPTURE, WRITE, DONE.
REQ-016 IDLE -> CAPTURE at the edge where en=1 and acc_valid_i=1; en without acc_valid_i SHALL keep IDLE with no side effects.
REQ-017 At the IDLE->CAPTURE edge SHALL register all four lanes; later changes on acc_data_i SHALL not affect the written data.
REQ-018 In CAPTURE (exactly one cycle) acc_clr_o SHALL be 4'b1111; otherwise 4'b0000.
REQ-019 CAPTURE -> WRITE unconditionally; a 2-bit lane counter SHALL be reset to 0 on entry.
REQ-020 In WRITE SHALL assert we_o=1, addr_o=(BASE_ADDR+lane) mod 64, mem_data_o=Q(lane); lane increments each cycle; after lane 3 -> DONE (exactly four write cycles).
REQ-021 Q(x) SHALL be x>>>SHIFT (sign-preserving), then saturated: >127 -> 127, <-128 -> -128, else low 8 bits.
REQ-022 Address SHALL wrap modulo 64 (BASE_ADDR=62 writes 62,63,0,1).
REQ-023 In DONE (one cycle) is_done_o=1; DONE -> IDLE unconditionally.
REQ-024 en or acc_valid_i while busy_o=1 SHALL be ignored; no queuing.
REQ-025 Start-to-done latency SHALL be fixed: en sampled at edge 0, CAPTURE cycle 1, writes cycles 2-5, is_done_o cycle 6, IDLE cycle 7; earliest restart sampled at edge 7.
REQ-026 All outputs SHALL be functions of registered state only; no combinational input-to-output path.
REQ-027 Outside WRITE, addr_o and mem_data_o SHALL be 0 and we_o 0.

Reset
REQ-028 rst=0 SHALL asynchronously force IDLE, lane counter 0, capture registers 0, all outputs 0.
REQ-029 Reset asserted mid-WRITE SHALL abort immediately; no further we_o pulses and no is_done_o for that job.
REQ-030 After rst deasserts, first start SHALL be accepted no earlier than the first rising edge with rst=1.

Structure
REQ-031 FSM state encoding, lane count (4) and memory address width (6) SHALL live in the shared custom package.
REQ-032 Quantization (REQ-021) SHALL be a sub-module custom_sat_quant, parameterized by ACC_W and SHIFT, purely combinational, one instance muxed by lane.

Verification
REQ-033 Lanes {100,-50,2000,-3000}, SHIFT=4, BASE=32, en+valid one cycle -> writes addr 32..35 data {6,-4,125,-128}, acc_clr_o high one cycle at cycle 1, is_done_o at cycle 6.
REQ-034 Lanes {4095,-4096,16,-17} -> data {127,-128,1,-2} (saturation and floor-rounding of negatives).
REQ-035 BASE_ADDR=62 -> addresses 62,63,0,1 in order.
REQ-036 en=1 with acc_valid_i=0 for 10 cycles -> busy_o, we_o, acc_clr_o stay 0; en held high throughout a job -> exactly 4 writes, next job starts cycle 7.
REQ-037 rst pulled low during second write cycle -> we_o drops asynchronously, no is_done_o, next job after reset writes all four lanes correctly.
REQ-038 acc_data_i changed during WRITE -> written data equals values captured at start.
